// File: rtl/systolic_feeder.sv
// Front-end feeder for an N x N systolic array: loads N weight rows, then streams
// activation vectors into the left edge with a per-row skew of r+1 cycles.
module systolic_feeder #(
    parameter int unsigned D_W    = 8,
    parameter int unsigned N      = 3,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   w_base,
    input  logic [ADDR_W-1:0]   a_base,
    input  logic [ADDR_W-1:0]   num_vec,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [N*D_W-1:0]    mem_rdata,
    output logic                load_w,
    output logic [1:0]          load_idx,
    output logic [N*D_W-1:0]    w_in_bus,
    output logic [N*D_W-1:0]    b_in_bus,
    output logic                busy,
    output logic                done
);

    localparam int unsigned BUS_W = N * D_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADW  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   w_base_q;
    logic [ADDR_W-1:0]   a_base_q;
    logic [ADDR_W-1:0]   num_q;
    logic [ADDR_W-1:0]   cnt;
    logic                act_valid;
    logic [D_W-1:0]      dl [N][N];

    // Sequencer: cnt indexes weight rows in LOADW, vectors in STREAM, drain cycles in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            w_base_q  <= '0;
            a_base_q  <= '0;
            num_q     <= '0;
            cnt       <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            load_w    <= 1'b0;
            load_idx  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            act_valid <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            load_w    <= 1'b0;
            load_idx  <= '0;
            done      <= 1'b0;
            act_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse is deliberately dropped.
                    if (start && !done) begin
                        w_base_q  <= w_base;
                        a_base_q  <= a_base;
                        num_q     <= num_vec;
                        cnt       <= '0;
                        state     <= LOADW;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= w_base;
                        busy      <= 1'b1;
                    end
                end
                LOADW: begin
                    load_w   <= 1'b1;
                    load_idx <= 2'(cnt);
                    if (cnt == ADDR_W'(N - 1)) begin
                        cnt <= '0;
                        if (num_q != '0) begin
                            state     <= STREAM;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= a_base_q;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        cnt       <= cnt + ADDR_W'(1);
                        mem_rd_en <= 1'b1;
                        mem_addr  <= w_base_q + cnt + ADDR_W'(1);
                    end
                end
                STREAM: begin
                    act_valid <= 1'b1;
                    if (cnt == num_q - ADDR_W'(1)) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end else begin
                        cnt       <= cnt + ADDR_W'(1);
                        mem_rd_en <= 1'b1;
                        mem_addr  <= a_base_q + cnt + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (cnt == ADDR_W'(N)) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-row skew lines; row r is tapped at stage r, giving r+1 cycles of delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(N); r++) begin
                for (int s = 0; s < int'(N); s++) begin
                    dl[r][s] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < int'(N); r++) begin
                dl[r][0] <= act_valid ? mem_rdata[r*D_W +: D_W] : '0;
                for (int s = 1; s < int'(N); s++) begin
                    dl[r][s] <= dl[r][s-1];
                end
            end
        end
    end

    always_comb begin
        b_in_bus = '0;
        for (int r = 0; r < int'(N); r++) begin
            b_in_bus[r*D_W +: D_W] = dl[r][r];
        end
    end

    // SRAM data arrives in the same cycle as the registered load strobe, so it is gated, not registered.
    assign w_in_bus = load_w ? mem_rdata : BUS_W'(0);

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Upstream stage of the N×N systolic array. On `start` it fetches N weight rows from on-chip SRAM and loads them into the array one row per cycle. It then streams `num_vec` activation vectors from SRAM into the array's left edge, skewing row r by r cycles so that the diagonal wavefront is correct. A drain phase follows, and the block reports completion with a one-cycle `done` pulse.

## Interface
- `D_W`, 8, activation/weight element width
- `N`, 3, array dimension (rows = columns); `load_idx` is 2 bits, so N ≤ 4
- `ADDR_W`, 8, SRAM word-address width
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle request; honoured only in IDLE
- `w_base`  in  ADDR_W  address of weight row 0; row i is at `w_base+i`
- `a_base`  in  ADDR_W  address of activation vector 0; vector j is at `a_base+j`
- `num_vec`  in  ADDR_W  number of activation vectors M (0 allowed)
- `mem_rd_en`  out  1  SRAM read strobe
- `mem_addr`  out  ADDR_W  SRAM read address
- `mem_rdata`  in  N*D_W  SRAM data, valid exactly 1 cycle after `mem_rd_en`; element k is at bits `[k*D_W +: D_W]`
- `load_w`  out  1  weight-load strobe to the array
- `load_idx`  out  2  array row being loaded
- `w_in_bus`  out  N*D_W  weight row; element c goes to column c
- `b_in_bus`  out  N*D_W  skewed activations; slice r drives array row r
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle exclusive
- `done`  out  1  one-cycle completion pulse

## Operation
- **FSM states:** IDLE → LOADW → STREAM → DRAIN → IDLE.
- **IDLE:** `start`=1 latches `w_base`, `a_base` and `num_vec`, then moves to LOADW.
- **LOADW (N cycles):**
  - Issues reads at `w_base+0 .. w_base+N-1`.
  - One cycle after read i, drives `load_w`=1, `load_idx`=i and `w_in_bus`=`mem_rdata`.
  - After the Nth read: goes to STREAM if M>0, else to DRAIN.
- **STREAM (M cycles):**
  - Issues reads at `a_base+j` for j=0..M-1, one per cycle, with no bubbles.
  - Returned element r of vector j enters a per-row delay line of depth r+1.
  - `b_in_bus[r]` carries element r of vector j exactly r+1 cycles after the data returns.
- **DRAIN (N+1 cycles):**
  - No reads are issued.
  - The delay lines empty.
  - On exit, `done` pulses, `busy` drops and the FSM returns to IDLE.
- **Zero fill:** any `b_in_bus` slice with no valid activation in flight is 0. `w_in_bus` is 0 when `load_w`=0.
- **Address arithmetic:** wraps modulo 2^ADDR_W.
- **Ignored `start`:** `start` during any state other than IDLE has no effect. Latched parameters stay stable for the whole operation.
- **Reset:** asynchronous reset in any state forces the FSM to IDLE, clears all delay lines and aborts the operation. No `done` pulse is generated.
- **Reset values:** every output is 0 — `mem_rd_en`, `mem_addr`, `load_w`, `load_idx`, `w_in_bus`, `b_in_bus`, `busy` and `done`.

## Timing
- **Cycle numbering:** cycle 0 is the cycle in which `start` is sampled high in IDLE.
- **Weight reads:** `mem_rd_en`=1 in cycles 1..N, with `mem_addr`=`w_base+i` in cycle i+1.
- **Weight loads:** `load_w`=1 in cycles 2..N+1, with `load_idx`=i in cycle i+2.
- **Activation reads:** in cycle N+1+j, `mem_rd_en`=1 and `mem_addr`=`a_base+j`, for j<M. Weight data return and the first activation read overlap in cycle N+1.
- **Activation arrival:** element r of vector j appears on `b_in_bus[r]` in cycle N+3+j+r.
  - Row 0 first sees data in cycle N+3, after all weights are loaded.
- **DRAIN:** occupies cycles N+M+1 .. 2N+M+1.
  - The last valid activation (row N-1, vector M-1) appears in cycle 2N+M+1.
- **Completion:** `done`=1 in cycle 2N+M+2. `busy`=1 in cycles 1..2N+M+1.
- **Back-to-back operations:** a `start` in the `done` cycle is ignored. The earliest accepted `start` is in cycle 2N+M+3.
- **M=0:** `done` falls in cycle 2N+2.

## Test plan
1. **Reset values:** assert `rst` asynchronously mid-clock → all outputs 0 immediately; FSM in IDLE.
2. **Weight load:** N=3, `w_base`=0x10, SRAM rows {0x030201, 0x060504, 0x090807}, M=0.
   - `load_w` in cycles 2,3,4 with `load_idx` 0,1,2 and `w_in_bus` equal to those rows.
   - `done` in cycle 8.
3. **Activation skew:** `a_base`=0x20, M=2, vectors {0x0C0B0A, 0x0F0E0D}.
   - `b_in_bus` row0: 0x0A at cycle 6, 0x0D at cycle 7.
   - row1: 0x0B at 7, 0x0E at 8.
   - row2: 0x0C at 8, 0x0F at 9.
   - All other row values 0; `done` in cycle 10.
4. **Address wrap:** `a_base`=0xFF, M=2 → read addresses 0xFF then 0x00.
5. **Start while busy:** pulse `start` during STREAM with different bases → no effect on addresses or on `done` timing.
6. **Reset mid-STREAM:** assert `rst` at cycle 6 of test 3.
   - All outputs 0 and no `done`.
   - A fresh `start` then reproduces test 3 exactly.
